// File: rtl/vid_pix_prefetch.sv
// Frame pixel prefetch: bursts 64-bit DDR words into a local FWFT FIFO and
// unpacks them into 16-bit pixels on demand, with sticky per-frame error flags.
module vid_pix_prefetch #(
  parameter int unsigned PIX_W       = 16,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned AW          = 9,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FRAME_WORDS = 230400,
  parameter int unsigned RA_W        = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vs_in,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [RA_W-1:0]   req_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pix_rd_en,
  output logic [PIX_W-1:0]  pix_data,
  output logic [AW:0]       level,
  output logic              underflow,
  output logic              overflow
);

  localparam int unsigned Depth = 2 ** AW;
  localparam int unsigned BlW   = $clog2(BURST_LEN + 1);

  localparam logic [AW:0]     SpaceMax = (AW + 1)'(Depth - BURST_LEN);
  localparam logic [AW:0]     DepthL   = (AW + 1)'(Depth);
  localparam logic [RA_W-1:0] FrameEnd = RA_W'(FRAME_WORDS);
  localparam logic [RA_W-1:0] BurstA   = RA_W'(BURST_LEN);
  localparam logic [BlW-1:0]  BurstB   = BlW'(BURST_LEN);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StFlush} state_e;

  state_e              state_q, state_d;
  logic                vs_q;
  logic [RA_W-1:0]     req_addr_q, req_addr_d;
  logic [BlW-1:0]      beats_q, beats_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         level_q, level_d;
  logic [1:0]          sel_q, sel_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                under_q, under_d, over_q, over_d;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic                vs_rise, fifo_empty, fifo_full, beat, wr_en, pop_pix, pop_word;
  logic [BlW-1:0]      beats_after;
  logic [DATA_W-1:0]   head;

  assign vs_rise     = vs_in & ~vs_q;
  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == DepthL);
  assign head        = mem_q[rd_ptr_q];
  assign beat        = in_valid && (state_q == StWait || state_q == StFlush);
  assign beats_after = beats_q - BlW'(beat);
  // A frame restart discards the beat of the same cycle.
  assign wr_en       = in_valid && (state_q == StWait) && !fifo_full && !vs_rise;
  assign pop_pix     = pix_rd_en && !fifo_empty;
  assign pop_word    = pop_pix && (sel_q == 2'd3);

  // Space only grows while in StReq, so once raised the request stays stable.
  assign req_valid = (state_q == StReq) && (level_q <= SpaceMax) && !vs_rise;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    beats_d    = beats_q;
    unique case (state_q)
      StIdle: ;
      StReq: begin
        if (req_valid && req_ready) begin
          req_addr_d = req_addr_q + BurstA;
          beats_d    = BurstB;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (in_valid) begin
          beats_d = beats_after;
          if (beats_after == '0) state_d = (req_addr_q == FrameEnd) ? StDone : StReq;
        end
      end
      StFlush: begin
        if (in_valid) begin
          beats_d = beats_after;
          if (beats_after == '0) state_d = StReq;
        end
      end
      StDone: ;
      default: state_d = StIdle;
    endcase
    if (vs_rise) begin
      req_addr_d = '0;
      beats_d    = beats_after;
      state_d    = ((state_q == StWait || state_q == StFlush) && beats_after != '0)
                   ? StFlush : StReq;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sel_d    = sel_q;
    pix_d    = pix_q;
    under_d  = under_q;
    over_d   = over_q;
    level_d  = level_q + (AW + 1)'(wr_en) - (AW + 1)'(pop_word);
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_pix) begin
      pix_d = head[int'(sel_q) * PIX_W +: PIX_W];
      sel_d = sel_q + 2'd1;
      if (pop_word) rd_ptr_d = rd_ptr_q + 1'b1;
    end else if (pix_rd_en) begin
      pix_d   = '0;
      under_d = 1'b1;
    end
    if (in_valid && (state_q == StWait) && fifo_full) over_d = 1'b1;
    if (vs_rise) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      sel_d    = '0;
      level_d  = '0;
      under_d  = 1'b0;
      over_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vs_q       <= 1'b0;
      req_addr_q <= '0;
      beats_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sel_q      <= '0;
      pix_q      <= '0;
      under_q    <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_in;
      req_addr_q <= req_addr_d;
      beats_q    <= beats_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sel_q      <= sel_d;
      pix_q      <= pix_d;
      under_q    <= under_d;
      over_q     <= over_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign req_addr  = req_addr_q;
  assign pix_data  = pix_q;
  assign level     = level_q;
  assign underflow = under_q;
  assign overflow  = over_q;

endmodule
